// File: rtl/wavelet53_lift_stream_if.sv
// Pair-stream bundle for the 5/3 lifting block: input pair channel and output pair channel,
// each with a valid/ready handshake. The block connects through the slave modport.
interface wavelet53_lift_stream_if #(
  parameter int DATA_W = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_even;
  logic signed [DATA_W-1:0] in_odd;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_even;
  logic signed [DATA_W-1:0] out_odd;
  logic                     out_last;

  modport slave (
    input  in_valid, in_even, in_odd, out_ready,
    output in_ready, out_valid, out_even, out_odd, out_last
  );

  modport master (
    output in_valid, in_even, in_odd, out_ready,
    input  in_ready, out_valid, out_even, out_odd, out_last
  );
endinterface

// File: rtl/wavelet53_lift_stream.sv
// Streaming LeGall 5/3 lifting row transform (forward/inverse per line) with symmetric
// extension, one output register and only the previous pair and previous d held as history.
module wavelet53_lift_stream #(
  parameter int DATA_W    = 16,
  parameter int LINE_LEN  = 64,
  parameter int NUM_LINES = 64,
  parameter int LINE_W    = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 inv_mode,
  wavelet53_lift_stream_if.slave io,
  output logic [LINE_W-1:0]    line_idx,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int P     = LINE_LEN / 2;
  localparam int CNT_W = $clog2(P + 1);
  localparam int SUM_W = DATA_W + 2;

  typedef logic signed [DATA_W-1:0] smp_t;
  typedef logic signed [SUM_W-1:0]  sum_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRST,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_e;

  // floor((a+b)/2), sum widened so it never overflows before the shift
  function automatic smp_t half_sum(input smp_t a, input smp_t b);
    sum_t s;
    s = {{2{a[DATA_W-1]}}, a} + {{2{b[DATA_W-1]}}, b};
    s = s >>> 1;
    return s[DATA_W-1:0];
  endfunction

  // floor((a+b+2)/4)
  function automatic smp_t quarter_sum(input smp_t a, input smp_t b);
    sum_t s;
    s = {{2{a[DATA_W-1]}}, a} + {{2{b[DATA_W-1]}}, b} + sum_t'(2);
    s = s >>> 2;
    return s[DATA_W-1:0];
  endfunction

  state_e            state_q, state_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mode_q, mode_d;
  smp_t              prev_even_q, prev_even_d;
  smp_t              prev_odd_q, prev_odd_d;
  smp_t              prev_d_q, prev_d_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  smp_t              out_even_q, out_even_d;
  smp_t              out_odd_q, out_odd_d;

  logic in_ready_w, in_acc, out_acc, flushing, use_d0, load, load_last;
  smp_t even_next, fwd_d, fwd_dm1, fwd_s;
  smp_t inv_dm1, inv_xe, inv_xn, inv_xo;
  smp_t res_even, res_odd, res_d;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    line_d      = line_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    prev_even_d = prev_even_q;
    prev_odd_d  = prev_odd_q;
    prev_d_d    = prev_d_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_even_d  = out_even_q;
    out_odd_d   = out_odd_q;
    load        = 1'b0;
    load_last   = 1'b0;

    in_ready_w = ((state_q == S_FIRST) || (state_q == S_RUN)) && (!out_valid_q || io.out_ready);
    in_acc     = io.in_valid && in_ready_w;
    out_acc    = out_valid_q && io.out_ready;
    flushing   = (state_q == S_FLUSH);
    // Output pair 0 mirrors d[-1] onto d[0]
    use_d0     = (cnt_q == CNT_W'(1));

    // Forward: the right-edge mirror x[2P] = x[2P-2] is the flush case
    even_next = flushing ? prev_even_q : io.in_even;
    fwd_d     = prev_odd_q - half_sum(prev_even_q, even_next);
    fwd_dm1   = use_d0 ? fwd_d : prev_d_q;
    fwd_s     = prev_even_q + quarter_sum(fwd_dm1, fwd_d);

    // Inverse: x[2k] of the incoming pair is rebuilt on the fly for the odd update
    inv_dm1 = use_d0 ? prev_odd_q : prev_d_q;
    inv_xe  = prev_even_q - quarter_sum(inv_dm1, prev_odd_q);
    inv_xn  = flushing ? inv_xe : (io.in_even - quarter_sum(prev_odd_q, io.in_odd));
    inv_xo  = prev_odd_q + half_sum(inv_xe, inv_xn);

    res_even = mode_q ? inv_xe : fwd_s;
    res_odd  = mode_q ? inv_xo : fwd_d;
    res_d    = mode_q ? prev_odd_q : fwd_d;

    if (out_acc) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FIRST;
          line_d  = '0;
        end
      end
      S_FIRST: begin
        if (in_acc) begin
          mode_d      = inv_mode;
          prev_even_d = io.in_even;
          prev_odd_d  = io.in_odd;
          cnt_d       = CNT_W'(1);
          state_d     = (P == 1) ? S_FLUSH : S_RUN;
        end
      end
      S_RUN: begin
        if (in_acc) begin
          load        = 1'b1;
          prev_even_d = io.in_even;
          prev_odd_d  = io.in_odd;
          cnt_d       = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(P - 1)) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (out_valid_q && out_last_q) begin
          if (io.out_ready) begin
            if (line_q == LINE_W'(NUM_LINES - 1)) begin
              state_d = S_DONE;
            end else begin
              line_d  = line_q + LINE_W'(1);
              state_d = S_FIRST;
            end
          end
        end else if (!out_valid_q || io.out_ready) begin
          load      = 1'b1;
          load_last = 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      out_valid_d = 1'b1;
      out_last_d  = load_last;
      out_even_d  = res_even;
      out_odd_d   = res_odd;
      prev_d_d    = res_d;
    end
  end

  // NOTE: data registers are reset along with control so outputs are defined from reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      line_q      <= '0;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      prev_even_q <= '0;
      prev_odd_q  <= '0;
      prev_d_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_even_q  <= '0;
      out_odd_q   <= '0;
    end else begin
      // NOTE: non-blocking so every flop updates from the same pre-edge values.
      state_q     <= state_d;
      line_q      <= line_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      prev_even_q <= prev_even_d;
      prev_odd_q  <= prev_odd_d;
      prev_d_q    <= prev_d_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_even_q  <= out_even_d;
      out_odd_q   <= out_odd_d;
    end
  end

  assign io.in_ready  = in_ready_w;
  assign io.out_valid = out_valid_q;
  assign io.out_even  = out_even_q;
  assign io.out_odd   = out_odd_q;
  assign io.out_last  = out_last_q;
  assign line_idx     = line_q;
  assign busy         = (state_q != S_IDLE);
  assign frame_done   = (state_q == S_DONE);

endmodule

// File: tb/tb_wavelet53_lift_stream.sv
// Scoreboard bench for wavelet53_lift_stream: three instances (8x3, 2x1, 64x1) share one
// stimulus driver selected by sel; a negedge monitor pops expected pairs as outputs transfer.
module tb_wavelet53_lift_stream;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]          sel = 2'd0;
  logic                start = 1'b0, inv_mode = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic signed [DW-1:0] in_even = '0, in_odd = '0;
  logic                rnd_rdy = 1'b1, force_rdy = 1'b0;

  wavelet53_lift_stream_if #(.DATA_W(DW)) if8 (), if2 (), if64 ();
  logic [6:0] li8, li2, li64;
  logic busy8, busy2, busy64, fd8, fd2, fd64;

  assign if8.in_valid   = in_valid && (sel == 2'd0);
  assign if2.in_valid   = in_valid && (sel == 2'd1);
  assign if64.in_valid  = in_valid && (sel == 2'd2);
  assign if8.in_even    = in_even;  assign if8.in_odd  = in_odd;
  assign if2.in_even    = in_even;  assign if2.in_odd  = in_odd;
  assign if64.in_even   = in_even;  assign if64.in_odd = in_odd;
  assign if8.out_ready  = out_ready;
  assign if2.out_ready  = out_ready;
  assign if64.out_ready = out_ready;

  wavelet53_lift_stream #(.DATA_W(DW), .LINE_LEN(8), .NUM_LINES(3), .LINE_W(7)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start && (sel == 2'd0)), .inv_mode(inv_mode),
    .io(if8), .line_idx(li8), .busy(busy8), .frame_done(fd8));
  wavelet53_lift_stream #(.DATA_W(DW), .LINE_LEN(2), .NUM_LINES(1), .LINE_W(7)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start && (sel == 2'd1)), .inv_mode(inv_mode),
    .io(if2), .line_idx(li2), .busy(busy2), .frame_done(fd2));
  wavelet53_lift_stream #(.DATA_W(DW), .LINE_LEN(64), .NUM_LINES(1), .LINE_W(7)) u64 (
    .clk(clk), .rst_n(rst_n), .start(start && (sel == 2'd2)), .inv_mode(inv_mode),
    .io(if64), .line_idx(li64), .busy(busy64), .frame_done(fd64));

  logic                 in_ready_m, out_valid_m, out_last_m, busy_m, fd_m;
  logic signed [DW-1:0] out_even_m, out_odd_m;
  logic [6:0]           li_m;
  int                   nl_m;

  always_comb begin
    in_ready_m = if8.in_ready;  out_valid_m = if8.out_valid; out_last_m = if8.out_last;
    out_even_m = if8.out_even;  out_odd_m = if8.out_odd;     busy_m = busy8;
    fd_m = fd8;                 li_m = li8;                  nl_m = 3;
    if (sel == 2'd1) begin
      in_ready_m = if2.in_ready;  out_valid_m = if2.out_valid; out_last_m = if2.out_last;
      out_even_m = if2.out_even;  out_odd_m = if2.out_odd;     busy_m = busy2;
      fd_m = fd2;                 li_m = li2;                  nl_m = 1;
    end else if (sel == 2'd2) begin
      in_ready_m = if64.in_ready; out_valid_m = if64.out_valid; out_last_m = if64.out_last;
      out_even_m = if64.out_even; out_odd_m = if64.out_odd;     busy_m = busy64;
      fd_m = fd64;                li_m = li64;                  nl_m = 1;
    end
  end

  always @(posedge clk) begin
    #1 out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : force_rdy;
  end

  typedef struct { int e; int o; bit last; } exp_t;
  exp_t exp_q[$];
  int   n_checks = 0, n_pass = 0, fd_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push_exp(input int e, input int o, input bit last);
    exp_t x;
    x.e = e; x.o = o; x.last = last;
    exp_q.push_back(x);
  endtask

  task automatic send_pair(input int e, input int o);
    bit ok;
    int n;
    in_even = DW'(e); in_odd = DW'(o); in_valid = 1'b1;
    ok = 1'b0; n = 0;
    while (!ok && n < 300) begin
      @(negedge clk); ok = in_ready_m;
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b0;
    check("input_accepted", int'(ok), 1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int exp_frames);
    int n;
    n = 0;
    while ((busy_m || exp_q.size() != 0) && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    check("busy_after_frame", int'(busy_m), 0);
    check("scoreboard_drained", exp_q.size(), 0);
    check("frame_done_count", fd_cnt, exp_frames);
  endtask

  // One 8-sample line: expected outputs queued, inv_mode flipped right after pair 0
  task automatic line8(input int vin[8], input int vout[8], input logic mode);
    for (int i = 0; i < 4; i++) push_exp(vout[2*i], vout[2*i+1], i == 3);
    for (int i = 0; i < 4; i++) begin
      if (i == 0) inv_mode = mode;
      send_pair(vin[2*i], vin[2*i+1]);
      if (i == 0) inv_mode = ~mode;
    end
  endtask

  // Monitor: pairs transfer at the edge after a negedge that sees valid && ready
  initial begin
    bit   stall, fd_pend;
    int   exp_line;
    exp_t hold, x;
    stall = 0; fd_pend = 0; exp_line = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 0; fd_pend = 0; exp_line = 0;
      end else begin
        if (fd_m) fd_cnt++;
        if (fd_pend || fd_m) check("frame_done_timing", int'(fd_m), int'(fd_pend));
        fd_pend = 0;
        if (stall) begin
          check("stall_valid_held", int'(out_valid_m), 1);
          check("stall_even_held", int'(out_even_m), hold.e);
          check("stall_odd_held", int'(out_odd_m), hold.o);
          check("stall_last_held", int'(out_last_m), int'(hold.last));
        end
        if (out_valid_m && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output", 1, 0);
          end else begin
            x = exp_q.pop_front();
            check("out_even", int'(out_even_m), x.e);
            check("out_odd", int'(out_odd_m), x.o);
            check("out_last", int'(out_last_m), int'(x.last));
          end
          if (out_last_m) begin
            check("line_idx", int'(li_m), exp_line);
            if (exp_line == nl_m - 1) begin
              fd_pend = 1; exp_line = 0;
            end else begin
              exp_line++;
            end
          end
        end
        stall  = out_valid_m && !out_ready;
        hold.e = int'(out_even_m); hold.o = int'(out_odd_m); hold.last = out_last_m;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int ramp    [8] = '{0, 1, 2, 3, 4, 5, 6, 7};
  int ramp_f  [8] = '{0, 0, 2, 0, 4, 0, 6, 1};
  int neg_in  [8] = '{10, -4, -7, 20, -8, -2, 0, 5};
  int neg_out [8] = '{8, -5, -1, 28, 0, 2, 2, 5};

  initial begin
    int n;
    int frames;
    frames = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    sel = 2'd0;
    @(posedge clk); #1;
    check("reset_out_valid", int'(out_valid_m), 0);
    check("reset_out_last", int'(out_last_m), 0);
    check("reset_busy", int'(busy_m), 0);
    check("reset_frame_done", int'(fd_m), 0);
    check("reset_line_idx", int'(li_m), 0);
    check("reset_in_ready", int'(in_ready_m), 0);

    // 3-line frame: forward ramp, its inverse, forward with negatives; start mid-frame ignored
    pulse_start();
    check("busy_after_start", int'(busy_m), 1);
    line8(ramp, ramp_f, 1'b0);
    pulse_start();
    line8(ramp_f, ramp, 1'b1);
    line8(neg_in, neg_out, 1'b0);
    frames++;
    wait_idle(frames);

    // Two-sample lines: FIRST goes straight to FLUSH
    sel = 2'd1;
    push_exp(1, 7, 1'b1);           inv_mode = 1'b0; pulse_start(); send_pair(-3, 4);
    frames++; wait_idle(frames);
    push_exp(-3, 4, 1'b1);          inv_mode = 1'b1; pulse_start(); send_pair(1, 7);
    frames++; wait_idle(frames);
    push_exp(-32768, 1, 1'b1);      inv_mode = 1'b0; pulse_start(); send_pair(32767, -32768);
    frames++; wait_idle(frames);
    push_exp(32767, -32768, 1'b1);  inv_mode = 1'b1; pulse_start(); send_pair(-32768, 1);
    frames++; wait_idle(frames);

    // Constant 64-sample line under random backpressure
    sel = 2'd2;
    for (int i = 0; i < 32; i++) push_exp(100, 0, i == 31);
    inv_mode = 1'b0;
    pulse_start();
    for (int i = 0; i < 32; i++) send_pair(100, 100);
    frames++; wait_idle(frames);

    // Reset two pairs into line 1, then a full frame again
    sel = 2'd0;
    pulse_start();
    line8(ramp, ramp_f, 1'b0);
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin @(posedge clk); #1; n++; end
    check("line0_drained", exp_q.size(), 0);
    rnd_rdy = 1'b0; force_rdy = 1'b0;
    @(posedge clk); #1;
    inv_mode = 1'b0;
    send_pair(0, 1);
    send_pair(2, 3);
    check("pre_reset_out_valid", int'(out_valid_m), 1);
    check("pre_reset_line_idx", int'(li_m), 1);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", int'(out_valid_m), 0);
    check("abort_busy", int'(busy_m), 0);
    check("abort_line_idx", int'(li_m), 0);
    @(posedge clk); #1;
    rst_n = 1'b1; rnd_rdy = 1'b1;
    @(posedge clk); #1;
    pulse_start();
    line8(neg_in, neg_out, 1'b0);
    line8(ramp_f, ramp, 1'b1);
    line8(ramp, ramp_f, 1'b0);
    frames++; wait_idle(frames);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
